fetch_align_q: RTL

FETCH_ALIGN_Q -- requirements
Module: fetch_align_q

---
 rtl/fetch_align_q.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_align_q.sv
// Fetch realignment queue: splits FW-bit fetch words into 16/32-bit instructions with PCs.
// Latency 1 cycle push-to-out_valid (no bypass); in_ready drops when fewer than FW/16 parcels are free.
module fetch_align_q #(
   parameter int          FW       = 64,
   parameter int          QD       = 8,
   parameter int          RVC_EN   = 1,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [31:0]   flush_pc,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [FW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic          out_isrv16,
   output logic [31:0]   out_pc
);

   localparam int NP = FW / 16;
   localparam int PW = $clog2(QD);
   localparam int SW = $clog2(NP);
   localparam int CW = PW + 1;

   logic [15:0]    q [QD];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count;
   logic [31:0]    pc;
   logic [SW-1:0]  skip;

   logic [15:0]    h0;
   logic [15:0]    h1;
   logic           is16;
   logic           push;
   logic           pop;
   logic [CW-1:0]  free;
   logic [CW-1:0]  push_n;
   logic [CW-1:0]  pop_n;
   logic [PW-1:0]  widx [NP];
   logic           wen [NP];

   always_comb begin
      h0         = q[head];
      h1         = q[head + PW'(1)];
      is16       = (RVC_EN != 0) && (h0[1:0] != 2'b11);
      out_valid  = is16 ? (count >= CW'(1)) : (count >= CW'(2));
      free       = CW'(QD) - count;
      in_ready   = (free >= CW'(NP));
      push       = in_valid && in_ready && !flush;
      pop        = out_valid && out_ready && !flush;
      push_n     = push ? (CW'(NP) - CW'(skip)) : '0;
      pop_n      = pop ? (is16 ? CW'(1) : CW'(2)) : '0;
      out_isrv16 = is16;
      out_instr  = is16 ? {16'h0000, h0} : {h1, h0};
      out_pc     = pc;
      // Parcels below skip belong to the previous fetch block and are dropped.
      for (int i = 0; i < NP; i++) begin
         wen[i]  = push && (i >= int'(skip));
         widx[i] = tail + PW'(i) - PW'(skip);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         pc    <= RESET_PC & 32'hFFFF_FFFE;
         skip  <= RESET_PC[SW:1];
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         pc    <= flush_pc & 32'hFFFF_FFFE;
         skip  <= flush_pc[SW:1];
      end else begin
         if (push) begin
            tail <= tail + PW'(push_n);
            skip <= '0;
         end
         if (pop) begin
            head <= head + PW'(pop_n);
            pc   <= pc + (is16 ? 32'd2 : 32'd4);
         end
         count <= count + push_n - pop_n;
      end
   end

   // Parcel storage needs no reset: validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (wen[i]) begin
            q[widx[i]] <= in_data[16*i +: 16];
         end
      end
   end

endmodule
